// File: rtl/udp_reg_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : udp_reg_slave_regfile
// Purpose  : Register-ring responder with saturating hardware counters and
//            read/write software registers; forwards the ring with 1-cycle lag.
// Revision : 1.0
// ============================================================================

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_slave_regfile #(
    parameter int TAG               = 'h1000,
    parameter int BLOCK_ADDR_WIDTH  = 6,
    parameter int NUM_CNTR          = 4,
    parameter int NUM_SW_REGS       = 4,
    parameter int COUNTER_WIDTH     = 32,
    parameter int RESET_ON_READ     = 0,
    parameter int UDP_REG_SRC_WIDTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic                                reg_req_in,
    input  logic                                reg_ack_in,
    input  logic                                reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_in,

    output logic                                reg_req_out,
    output logic                                reg_ack_out,
    output logic                                reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_out,

    input  logic [NUM_CNTR-1:0]                 counter_incr,
    output logic [NUM_SW_REGS*32-1:0]           sw_regs
);

    localparam int c_AW    = `UDP_REG_ADDR_WIDTH;
    localparam int c_DW    = `CPCI_NF2_DATA_WIDTH;
    localparam int c_TAG_W = c_AW - BLOCK_ADDR_WIDTH;
    localparam logic [c_TAG_W-1:0]       c_TAG     = c_TAG_W'(TAG);
    localparam logic [c_DW-1:0]          c_UNMAPPED = c_DW'(32'hDEAD_BEEF);
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_MAX = '1;

    logic                  w_claim;
    logic                  w_claim_rd;
    logic                  w_claim_wr;
    logic [31:0]           w_off32;
    logic [c_DW-1:0]       w_rd_data;
    logic [c_DW-1:0]       w_cntr_val [NUM_CNTR];
    logic [c_DW-1:0]       r_sw       [NUM_SW_REGS];

    assign w_claim    = reg_req_in && !reg_ack_in &&
                        (reg_addr_in[c_AW-1:BLOCK_ADDR_WIDTH] == c_TAG);
    assign w_claim_rd = w_claim &&  reg_rd_wr_L_in;
    assign w_claim_wr = w_claim && !reg_rd_wr_L_in;
    assign w_off32    = 32'(reg_addr_in[BLOCK_ADDR_WIDTH-1:0]);

    // Counters: saturating; a clearing read still keeps an increment from the same cycle
    generate
        for (genvar gi = 0; gi < NUM_CNTR; gi++) begin : g_cntr
            logic [COUNTER_WIDTH-1:0] r_cnt;
            logic                     w_hit;

            assign w_hit          = w_claim_rd && (w_off32 == 32'(gi));
            assign w_cntr_val[gi] = c_DW'(r_cnt);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if ((RESET_ON_READ != 0) && w_hit) begin
                    r_cnt <= counter_incr[gi] ? COUNTER_WIDTH'(1'b1) : '0;
                end else if (counter_incr[gi] && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + COUNTER_WIDTH'(1'b1);
                end
            end
        end
    endgenerate

    generate
        for (genvar gj = 0; gj < NUM_SW_REGS; gj++) begin : g_sw
            logic w_wr;

            assign w_wr = w_claim_wr && (w_off32 == 32'(NUM_CNTR + gj));
            assign sw_regs[32*gj +: 32] = 32'(r_sw[gj]);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sw[gj] <= '0;
                end else if (w_wr) begin
                    r_sw[gj] <= reg_data_in;
                end
            end
        end
    endgenerate

    always_comb begin
        w_rd_data = c_UNMAPPED;
        for (int i = 0; i < NUM_CNTR; i++) begin
            if (w_off32 == 32'(i)) begin
                w_rd_data = w_cntr_val[i];
            end
        end
        for (int j = 0; j < NUM_SW_REGS; j++) begin
            if (w_off32 == 32'(NUM_CNTR + j)) begin
                w_rd_data = r_sw[j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            reg_req_out     <= reg_req_in;
            reg_ack_out     <= reg_ack_in || w_claim;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= w_claim_rd ? w_rd_data : reg_data_in;
            reg_src_out     <= reg_src_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_udp_reg_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_reg_slave_regfile
// Purpose  : Scoreboard bench driving two responders (default build and a
//            4-bit clear-on-read build) with the same ring traffic.
// Revision : 1.0
// ============================================================================

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_slave_regfile;

    localparam int c_AW = `UDP_REG_ADDR_WIDTH;
    localparam int c_DW = `CPCI_NF2_DATA_WIDTH;

    typedef struct {
        logic            ack;
        logic            rd;
        logic [c_AW-1:0] addr;
        logic [1:0]      src;
        logic [c_DW-1:0] da;
        logic [c_DW-1:0] db;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_in = 1'b0, ack_in = 1'b0, rd_in = 1'b0;
    logic [c_AW-1:0]   addr_in = '0;
    logic [c_DW-1:0]   data_in = '0;
    logic [1:0]        src_in = '0;
    logic [3:0]        incr = '0;

    logic              a_req, a_ack, a_rd, b_req, b_ack, b_rd;
    logic [c_AW-1:0]   a_addr, b_addr;
    logic [c_DW-1:0]   a_data, b_data;
    logic [1:0]        a_src, b_src;
    logic [127:0]      a_sw, b_sw;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    udp_reg_slave_regfile dut_a (
        .clk(clk), .reset(reset),
        .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rd_in),
        .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
        .reg_req_out(a_req), .reg_ack_out(a_ack), .reg_rd_wr_L_out(a_rd),
        .reg_addr_out(a_addr), .reg_data_out(a_data), .reg_src_out(a_src),
        .counter_incr(incr), .sw_regs(a_sw)
    );

    udp_reg_slave_regfile #(.COUNTER_WIDTH(4), .RESET_ON_READ(1)) dut_b (
        .clk(clk), .reset(reset),
        .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rd_in),
        .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
        .reg_req_out(b_req), .reg_ack_out(b_ack), .reg_rd_wr_L_out(b_rd),
        .reg_addr_out(b_addr), .reg_data_out(b_data), .reg_src_out(b_src),
        .counter_incr(incr), .sw_regs(b_sw)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [c_AW-1:0] mk(input logic [16:0] tag, input int off);
        logic [31:0] o;
        o = off;
        return {tag, o[5:0]};
    endfunction

    // One ring request per call; the expected response goes to the scoreboard
    task automatic issue(input logic rd, input logic [c_AW-1:0] addr, input logic [31:0] data,
                         input logic ain, input logic [3:0] inc, input logic eack,
                         input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        req_in = 1'b1; ack_in = ain; rd_in = rd; addr_in = addr; data_in = data;
        src_in = 2'(addr[1:0] ^ 2'b10); incr = inc;
        e.ack = eack; e.rd = rd; e.addr = addr; e.src = src_in; e.da = ea; e.db = eb;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic [3:0] inc);
        req_in = 1'b0; ack_in = 1'b0; rd_in = 1'b0; addr_in = '0; data_in = '0;
        src_in = '0; incr = inc;
        repeat (n) @(posedge clk);
        #1;
        incr = '0;
    endtask

    always @(negedge clk) begin
        if (!reset && (a_req || a_ack || b_req || b_ack)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {a_req, a_ack, b_req, b_ack}, 4'b0000);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ring_a", {a_req, a_ack, a_rd, a_src, a_addr, a_data},
                              {1'b1, e.ack, e.rd, e.src, e.addr, e.da});
                chk("ring_b", {b_req, b_ack, b_rd, b_src, b_addr, b_data},
                              {1'b1, e.ack, e.rd, e.src, e.addr, e.db});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {a_req, a_ack, a_rd, a_addr, a_data, a_src, b_req, b_ack, b_data}, '0);
        chk("reset_sw_regs", {a_sw[63:0], b_sw[63:0]}, '0);
        reset = 1'b0;
        idle(2, 4'b0000);

        // Software register write then immediate read
        issue(1'b0, mk(17'h1000, 4), 32'hCAFE_0001, 1'b0, 4'b0, 1'b1, 32'hCAFE_0001, 32'hCAFE_0001);
        issue(1'b1, mk(17'h1000, 4), 32'h0, 1'b0, 4'b0, 1'b1, 32'hCAFE_0001, 32'hCAFE_0001);
        chk("sw_reg0", {a_sw[31:0], b_sw[31:0]}, {32'hCAFE_0001, 32'hCAFE_0001});
        issue(1'b0, mk(17'h1000, 7), 32'h1234_5678, 1'b0, 4'b0, 1'b1, 32'h1234_5678, 32'h1234_5678);
        issue(1'b1, mk(17'h1000, 7), 32'h0, 1'b0, 4'b0, 1'b1, 32'h1234_5678, 32'h1234_5678);
        issue(1'b1, mk(17'h1000, 8), 32'h0, 1'b0, 4'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk("sw_reg3", {a_sw[127:96], b_sw[127:96]}, {32'h1234_5678, 32'h1234_5678});

        // Counter 2: five increments, then reads with and without a same-cycle increment
        idle(5, 4'b0100);
        issue(1'b1, mk(17'h1000, 2), 32'h0, 1'b0, 4'b0000, 1'b1, 32'd5, 32'd5);
        issue(1'b1, mk(17'h1000, 2), 32'h0, 1'b0, 4'b0000, 1'b1, 32'd5, 32'd0);
        issue(1'b1, mk(17'h1000, 2), 32'h0, 1'b0, 4'b0100, 1'b1, 32'd5, 32'd0);
        issue(1'b1, mk(17'h1000, 2), 32'h0, 1'b0, 4'b0000, 1'b1, 32'd6, 32'd1);

        // Counter 1: 20 increments saturate the 4-bit build at 'hF
        idle(20, 4'b0010);
        issue(1'b1, mk(17'h1000, 1), 32'h0, 1'b0, 4'b0000, 1'b1, 32'd20, 32'hF);

        // Unmapped read, ignored counter write
        issue(1'b1, mk(17'h1000, 40), 32'h0, 1'b0, 4'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        issue(1'b0, mk(17'h1000, 1), 32'h5555, 1'b0, 4'b0, 1'b1, 32'h5555, 32'h5555);
        issue(1'b1, mk(17'h1000, 1), 32'h0, 1'b0, 4'b0, 1'b1, 32'd20, 32'd0);

        // Foreign tag and upstream-acked requests pass through untouched
        issue(1'b1, mk(17'h1001, 4), 32'h0BAD, 1'b0, 4'b0, 1'b0, 32'h0BAD, 32'h0BAD);
        issue(1'b0, mk(17'h1001, 5), 32'hAAAA, 1'b0, 4'b0, 1'b0, 32'hAAAA, 32'hAAAA);
        issue(1'b0, mk(17'h1000, 5), 32'h0099, 1'b1, 4'b0, 1'b1, 32'h0099, 32'h0099);
        issue(1'b1, mk(17'h1000, 5), 32'h0, 1'b0, 4'b0, 1'b1, 32'h0, 32'h0);
        chk("sw_reg1_untouched", {a_sw[63:32], b_sw[63:32]}, '0);
        idle(3, 4'b0000);
        chk("queue_drained", 128'(q.size()), '0);

        // Reset lands while a write is on the ring; that write is never acked
        req_in = 1'b1; ack_in = 1'b0; rd_in = 1'b0; addr_in = mk(17'h1000, 6); data_in = 32'h1234;
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_outputs", {a_req, a_ack, a_data, b_req, b_ack, b_data}, '0);
        chk("midreset_sw_regs", {a_sw, b_sw[31:0]}, '0);
        @(posedge clk); #1;
        req_in = 1'b0; data_in = '0; addr_in = '0;
        reset = 1'b0;
        idle(4, 4'b0000);
        chk("post_reset_sw_regs", {a_sw[127:64], b_sw[127:64]}, '0);
        chk("post_reset_no_ack", {a_ack, b_ack, a_req, b_req}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
